note_tone_gen: RTL and testbench



---
 rtl/note_tone_pkg.sv | 63 ++++++
 rtl/note_tone_gen_tick.sv | 29 ++
 rtl/note_tone_gen.sv | 166 ++++++++++++++++
 tb/tb_note_tone_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_tone_pkg.sv
// Shared types, widths and the half-period table for the note tone generator.
package note_tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int unsigned MAX_OCTAVE = 5;
  localparam int unsigned MAX_NOTE   = 11;
  localparam int unsigned HALF_W     = 19;
  localparam int unsigned OCT_W      = 3;
  localparam int unsigned NOTE_W     = 4;
  localparam int unsigned DUR_W      = 8;

  // Captured note request (octave, semitone, duration in ticks).
  typedef struct packed {
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } note_req_t;

  // Half-period in 25 MHz cycles for each semitone of the top octave.
  function automatic logic [HALF_W-1:0] note_half(input logic [NOTE_W-1:0] semi);
    logic [HALF_W-1:0] h;
    case (semi)
      4'd0:    h = 19'd11945;
      4'd1:    h = 19'd11274;
      4'd2:    h = 19'd10641;
      4'd3:    h = 19'd10044;
      4'd4:    h = 19'd9480;
      4'd5:    h = 19'd8948;
      4'd6:    h = 19'd8446;
      4'd7:    h = 19'd7972;
      4'd8:    h = 19'd7525;
      4'd9:    h = 19'd7102;
      4'd10:   h = 19'd6704;
      4'd11:   h = 19'd6327;
      default: h = '0;
    endcase
    return h;
  endfunction

  // Out-of-range octave or semitone plays as silence.
  function automatic logic is_rest(input logic [OCT_W-1:0] oct,
                                   input logic [NOTE_W-1:0] semi);
    return (semi > NOTE_W'(MAX_NOTE)) || (oct > OCT_W'(MAX_OCTAVE));
  endfunction

  // Half-period scaled down by octave: each octave below the top doubles it.
  function automatic logic [HALF_W-1:0] half_period(input logic [OCT_W-1:0] oct,
                                                    input logic [NOTE_W-1:0] semi);
    logic [OCT_W-1:0]  shamt;
    logic [HALF_W-1:0] h;
    shamt = OCT_W'(MAX_OCTAVE) - oct;
    if (is_rest(oct, semi)) h = '0;
    else                    h = note_half(semi) << shamt;
    return h;
  endfunction

endpackage

// File: rtl/note_tone_gen_tick.sv
// Duration prescaler: one-cycle tick every TICK_DIV cycles, synchronous clear.
module tick_gen #(
  parameter int unsigned TICK_DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == LAST);

  // Free-running modulo-TICK_DIV counter, restarted by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave note player: handshake in a note, play it for dur ticks, then a silent gap.
module note_tone_gen
  import note_tone_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25000,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [OCT_W-1:0]  octave,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  dur,
  input  logic              stop,
  output logic              speaker,
  output logic              busy,
  output logic              done
);

  localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  state_t            state, state_next;
  note_req_t         req, req_next;
  logic [HALF_W-1:0] half, half_next;
  logic              rest, rest_next;
  logic [HALF_W-1:0] tone_cnt, tone_next;
  logic [DUR_W-1:0]  dur_cnt, dur_next;
  logic [GAP_W-1:0]  gap_cnt, gap_next;
  logic              speaker_next;
  logic              busy_next;
  logic              done_next;

  logic              clear_c;
  logic              tick_c;
  logic              accept_c;
  logic [HALF_W-1:0] half_c;
  logic              rest_c;

  assign note_ready = (state == IDLE);
  assign accept_c   = note_valid && note_ready && !stop;
  assign half_c     = half_period(req.octave, req.note);
  assign rest_c     = is_rest(req.octave, req.note);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_c),
    .tick_c (tick_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= '0;
      half     <= '0;
      rest     <= 1'b0;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      speaker  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      req      <= req_next;
      half     <= half_next;
      rest     <= rest_next;
      tone_cnt <= tone_next;
      dur_cnt  <= dur_next;
      gap_cnt  <= gap_next;
      speaker  <= speaker_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  // Next-state, counter and output logic; stop overrides everything.
  always_comb begin
    state_next   = state;
    req_next     = req;
    half_next    = half;
    rest_next    = rest;
    tone_next    = tone_cnt;
    dur_next     = dur_cnt;
    gap_next     = gap_cnt;
    speaker_next = speaker;
    done_next    = 1'b0;
    clear_c      = 1'b1;

    case (state)
      IDLE: begin
        speaker_next = 1'b0;
        if (accept_c) begin
          req_next   = '{octave: octave, note: note, dur: dur};
          state_next = LOAD;
        end
      end

      LOAD: begin
        half_next    = half_c;
        rest_next    = rest_c;
        tone_next    = half_c - HALF_W'(1);
        dur_next     = req.dur;
        speaker_next = 1'b0;
        if (req.dur == '0) begin
          gap_next   = GAP_W'(GAP_TICKS);
          state_next = GAP;
        end else begin
          state_next = PLAY;
        end
      end

      PLAY: begin
        clear_c = 1'b0;
        if (tone_cnt == '0) begin
          tone_next = half - HALF_W'(1);
          if (!rest) speaker_next = ~speaker;
        end else begin
          tone_next = tone_cnt - HALF_W'(1);
        end
        if (tick_c) begin
          dur_next = dur_cnt - DUR_W'(1);
          // Last tick wins over a coincident tone reload.
          if (dur_cnt == DUR_W'(1)) begin
            speaker_next = 1'b0;
            gap_next     = GAP_W'(GAP_TICKS);
            state_next   = GAP;
          end
        end
      end

      GAP: begin
        clear_c      = 1'b0;
        speaker_next = 1'b0;
        if (gap_cnt == '0) begin
          // Cycle after the final gap tick carries done; leave afterwards.
          state_next = IDLE;
        end else if (tick_c) begin
          gap_next = gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) done_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (stop) begin
      state_next   = IDLE;
      speaker_next = 1'b0;
      done_next    = 1'b0;
      tone_next    = '0;
      dur_next     = '0;
      gap_next     = '0;
      clear_c      = 1'b1;
    end

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Scoreboard bench for note_tone_gen with a shortened tick (TICK_DIV=100).
module tb_note_tone_gen;

  localparam int TD  = 100;
  localparam int GT  = 10;
  localparam int GAP = TD * GT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       note_valid = 1'b0;
  logic       note_ready;
  logic [2:0] octave = '0;
  logic [3:0] note = '0;
  logic [7:0] dur = '0;
  logic       stop = 1'b0;
  logic       speaker;
  logic       busy;
  logic       done;

  always #20 clk = ~clk;

  note_tone_gen #(
    .TICK_DIV  (TD),
    .GAP_TICKS (GT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .octave     (octave),
    .note       (note),
    .dur        (dur),
    .stop       (stop),
    .speaker    (speaker),
    .busy       (busy),
    .done       (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected behaviour of one note.
  typedef struct packed {
    int half;
    int play;
    int ntog;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    tbl[12] = '{11945, 11274, 10641, 10044, 9480, 8948,
                     8446, 7972, 7525, 7102, 6704, 6327};

  function automatic exp_t model(input int oct, input int semi, input int d);
    exp_t e;
    bit   r;
    r      = (oct > 5) || (semi > 11);
    e.half = r ? 0 : (tbl[semi] << (5 - oct));
    e.play = d * TD;
    e.ntog = (r || e.play == 0) ? 0 : (e.play - 1) / e.half;
    return e;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state.
  int    hs_edge = 0, last_hs = 0, hs_cnt = 0;
  int    n_tr = 0, first_tr = 0, last_tr = 0;
  int    done_cnt = 0, last_done = 0;
  logic  prev_spk = 1'b0;
  bit    chk_after_done = 1'b0;
  exp_t  e;
  string en;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_spk       = 1'b0;
      chk_after_done = 1'b0;
    end else begin
      if (chk_after_done) begin
        check("ready_after_done", note_ready, 1);
        check("done_one_cycle", done, 0);
        chk_after_done = 1'b0;
      end
      if (speaker !== prev_spk) begin
        n_tr++;
        if (n_tr == 1) first_tr = cyc;
        last_tr = cyc;
      end
      prev_spk = speaker;
      if (done === 1'b1) begin
        done_cnt++;
        last_done = cyc;
        check("ready_low_in_done", note_ready, 0);
        check("speaker_low_in_done", speaker, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", done_cnt, 0);
        end else begin
          e  = sb.pop_front();
          en = sb_name.pop_front();
          check({en, "_done_latency"}, cyc - hs_edge, 1 + e.play + GAP);
          check({en, "_transitions"}, n_tr, e.ntog + (e.ntog % 2));
          if (e.ntog > 0) begin
            check({en, "_first_toggle"}, first_tr - hs_edge, 1 + e.half);
            check({en, "_last_edge"}, last_tr - hs_edge,
                  (e.ntog % 2 == 1) ? 1 + e.play : 1 + e.ntog * e.half);
          end
        end
        chk_after_done = 1'b1;
      end
      if (note_valid && note_ready && !stop) begin
        hs_edge = cyc + 1;
        last_hs = hs_edge;
        hs_cnt++;
        n_tr = 0;
      end
    end
  end

  // Present a note (called just after a posedge) and wait for its handshake.
  task automatic send(input int oct, input int semi, input int d, input string name,
                      input bit hold, input bit expect_done, input int budget);
    int start;
    int k;
    octave     = 3'(oct);
    note       = 4'(semi);
    dur        = 8'(d);
    note_valid = 1'b1;
    if (expect_done) begin
      sb.push_back(model(oct, semi, d));
      sb_name.push_back(name);
    end
    start = hs_cnt;
    k     = 0;
    while (hs_cnt == start && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_accepted"}, hs_cnt != start, 1);
    if (!hold) note_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    int k;
    start = done_cnt;
    k     = 0;
    while (done_cnt == start && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_done_seen"}, done_cnt != start, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic wait_spk_high(input string name, input int budget);
    int k;
    k = 0;
    while (speaker !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_speaker_high"}, speaker, 1);
  endtask

  task automatic idle_window(input string name, input int cycles);
    int d0;
    d0 = done_cnt;
    repeat (cycles) begin @(posedge clk); #1; end
    check({name, "_no_done"}, done_cnt, d0);
    check({name, "_speaker_quiet"}, speaker, 0);
  endtask

  initial begin
    #(64'd40 * 64'd95000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_speaker", speaker, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", note_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tones and rests.
    send(5, 9, 150, "a6", 1'b0, 1'b1, 100);
    @(negedge clk);
    check("busy_in_load", busy, 1);
    wait_done("a6", 20000);
    send(4, 11, 130, "b5", 1'b0, 1'b1, 100);
    wait_done("b5", 16000);
    send(6, 0, 20, "oct6_rest", 1'b0, 1'b1, 100);
    wait_done("oct6_rest", 4000);
    send(2, 12, 20, "note12_rest", 1'b0, 1'b1, 100);
    wait_done("note12_rest", 4000);
    send(3, 0, 0, "dur0", 1'b0, 1'b1, 100);
    wait_done("dur0", 2000);

    // stop mid-PLAY.
    send(5, 11, 70, "stop", 1'b0, 1'b0, 100);
    wait_spk_high("stop", 8000);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_speaker", speaker, 0);
    check("stop_busy", busy, 0);
    check("stop_ready", note_ready, 1);
    check("stop_done", done, 0);
    idle_window("stop", 2500);

    // Asynchronous reset mid-PLAY.
    send(5, 11, 70, "rst", 1'b0, 1'b0, 100);
    wait_spk_high("rst", 8000);
    #5 rst_n = 1'b0;
    #1;
    check("rst_speaker", speaker, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", note_ready, 1);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_window("rst", 2500);

    // Back-to-back with note_valid held; inputs change while the first note plays.
    send(5, 11, 70, "bb1", 1'b1, 1'b1, 100);
    send(3, 0, 0, "bb2", 1'b0, 1'b1, 12000);
    check("bb_accept_after_done", last_hs - last_done, 2);
    wait_done("bb2", 2000);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
